uart_mem_cmd_proc: RTL and testbench

- Parametrised ASCII command processor between the byte-level UART receiver/transmitter and a memory controller request port (SDRAM controller class).
- Parses hex write/read commands of configurable address/data width and drives a held request/done handshake to memory.
- Formats read data back as ASCII hex and reports errors and memory timeouts.
- Replaces the ad-hoc command-decode stub in the top level; single clock domain (UART and memory port on the same clock).

---
 rtl/uart_mem_cmd_proc.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_mem_cmd_proc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_cmd_proc.sv
// ASCII hex command processor: parses UART W/R commands, drives a held
// request/done handshake to a memory controller and returns ASCII responses.
module uart_mem_cmd_proc #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_req,
  output logic              mem_rd_req,
  input  logic              mem_wr_done,
  input  logic              mem_rd_ready,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_busy,
  output logic              busy,
  output logic [7:0]        err_count
);
  localparam int unsigned AD     = (ADDR_W + 3) / 4;
  localparam int unsigned DD     = (DATA_W + 3) / 4;
  localparam int unsigned MAXD   = (AD > DD) ? AD : DD;
  localparam int unsigned CNT_W  = $clog2(MAXD + 1);
  localparam int unsigned IDX_W  = $clog2(DD + 3);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned RD_PAD = DD * 4;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_EXEC, S_RESP, S_ERR} state_t;
  typedef enum logic [1:0] {R_WR_OK, R_RD_OK, R_PARSE, R_TMO} resp_t;

  state_t            state, state_d;
  resp_t             resp, resp_d;
  logic              is_wr, is_wr_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [TMR_W-1:0]  tmr, tmr_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [DATA_W-1:0] rdata, rdata_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              wr_req_d, rd_req_d, tx_send_d, busy_d;
  logic [7:0]        tx_data_d, err_d;
  logic              pend, pend_d, seen, seen_d;
  logic [1:0]        wcnt, wcnt_d;
  logic              release_now, tx_ready;
  logic [4:0]        dec;
  logic [7:0]        resp_byte;
  logic              resp_last;
  logic [RD_PAD-1:0] rpad;
  int unsigned       sh;

  // {valid, nibble} for an ASCII hex digit, case-insensitive
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  function automatic logic [7:0] hex_encode(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

  // Byte selected by the response kind and the current response index
  always_comb begin
    resp_byte = 8'h0A;
    resp_last = 1'b0;
    rpad      = RD_PAD'(rdata);
    sh        = 0;
    if (resp == R_RD_OK) begin
      if (idx < IDX_W'(DD)) begin
        sh        = 4 * (DD - 1 - 32'(idx));
        resp_byte = hex_encode(4'(rpad >> sh));
      end else if (idx == IDX_W'(DD)) begin
        resp_byte = 8'h0D;
      end else begin
        resp_last = 1'b1;
      end
    end else begin
      if (idx == IDX_W'(0)) begin
        resp_byte = (resp == R_WR_OK) ? 8'h4B : (resp == R_PARSE) ? 8'h3F : 8'h54;
      end else if (idx == IDX_W'(1)) begin
        resp_byte = 8'h0D;
      end else begin
        resp_last = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    resp_d    = resp;
    is_wr_d   = is_wr;
    cnt_d     = cnt;
    tmr_d     = tmr;
    idx_d     = idx;
    rdata_d   = rdata;
    addr_d    = mem_addr;
    wdata_d   = mem_wr_data;
    wr_req_d  = mem_wr_req;
    rd_req_d  = mem_rd_req;
    tx_data_d = tx_data;
    tx_send_d = 1'b0;
    err_d     = err_count;
    pend_d    = pend;
    seen_d    = seen;
    wcnt_d    = wcnt;
    dec       = hex_decode(rx_data);

    // Next byte allowed once busy was seen and fell, or 2 cycles with no busy at all
    release_now = 1'b0;
    if (pend) begin
      if (tx_busy)                      seen_d = 1'b1;
      else if (seen || wcnt == 2'd2)    release_now = 1'b1;
      else                              wcnt_d = wcnt + 2'd1;
    end
    if (release_now) begin
      pend_d = 1'b0;
      seen_d = 1'b0;
      wcnt_d = 2'd0;
    end
    tx_ready = !tx_busy && (!pend || release_now);

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h57 || rx_data == 8'h77 || rx_data == 8'h52 || rx_data == 8'h72) begin
            is_wr_d = (rx_data == 8'h57) || (rx_data == 8'h77);
            cnt_d   = '0;
            addr_d  = '0;
            wdata_d = '0;
            state_d = S_ADDR;
          end else if (!(rx_data == 8'h0D || rx_data == 8'h0A || rx_data == 8'h20)) begin
            state_d = S_ERR;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (dec[4]) begin
            addr_d = ADDR_W'({mem_addr, dec[3:0]});
            if (cnt == CNT_W'(AD - 1)) begin
              cnt_d = '0;
              if (is_wr) begin
                state_d = S_DATA;
              end else begin
                state_d  = S_EXEC;
                rd_req_d = 1'b1;
                tmr_d    = '0;
              end
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (dec[4]) begin
            wdata_d = DATA_W'({mem_wr_data, dec[3:0]});
            if (cnt == CNT_W'(DD - 1)) begin
              cnt_d    = '0;
              state_d  = S_EXEC;
              wr_req_d = 1'b1;
              tmr_d    = '0;
            end else begin
              cnt_d = cnt + CNT_W'(1);
            end
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_EXEC: begin
        // Completion wins over a timeout landing on the same cycle
        idx_d = '0;
        if (mem_wr_req && mem_wr_done) begin
          wr_req_d = 1'b0;
          resp_d   = R_WR_OK;
          state_d  = S_RESP;
        end else if (mem_rd_req && mem_rd_ready) begin
          rd_req_d = 1'b0;
          rdata_d  = mem_rd_data;
          resp_d   = R_RD_OK;
          state_d  = S_RESP;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          resp_d   = R_TMO;
          state_d  = S_RESP;
          err_d    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      S_ERR: begin
        idx_d   = '0;
        resp_d  = R_PARSE;
        state_d = S_RESP;
        err_d   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
      end
      S_RESP: begin
        if (tx_ready) begin
          tx_data_d = resp_byte;
          tx_send_d = 1'b1;
          pend_d    = 1'b1;
          seen_d    = 1'b0;
          wcnt_d    = 2'd0;
          if (resp_last) state_d = S_IDLE;
          else           idx_d   = idx + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      resp        <= R_WR_OK;
      is_wr       <= 1'b0;
      cnt         <= '0;
      tmr         <= '0;
      idx         <= '0;
      rdata       <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_req  <= 1'b0;
      mem_rd_req  <= 1'b0;
      tx_data     <= 8'd0;
      tx_send     <= 1'b0;
      busy        <= 1'b0;
      err_count   <= 8'd0;
      pend        <= 1'b0;
      seen        <= 1'b0;
      wcnt        <= 2'd0;
    end else begin
      state       <= state_d;
      resp        <= resp_d;
      is_wr       <= is_wr_d;
      cnt         <= cnt_d;
      tmr         <= tmr_d;
      idx         <= idx_d;
      rdata       <= rdata_d;
      mem_addr    <= addr_d;
      mem_wr_data <= wdata_d;
      mem_wr_req  <= wr_req_d;
      mem_rd_req  <= rd_req_d;
      tx_data     <= tx_data_d;
      tx_send     <= tx_send_d;
      busy        <= busy_d;
      err_count   <= err_d;
      pend        <= pend_d;
      seen        <= seen_d;
      wcnt        <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_uart_mem_cmd_proc.sv
// Directed bench: a default-width instance and a 10/9-bit TIMEOUT=16 instance
// share stimulus through a select; memory and transmitter are modelled here.
`timescale 1ns/1ps
module tb_uart_mem_cmd_proc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_done, mem_ready;
  logic [15:0] mem_rdata;
  logic        tx_busy;

  logic [23:0] addr0;  logic [15:0] wdata0; logic wr_req0, rd_req0;
  logic [7:0]  tx_data0; logic tx_send0, busy0; logic [7:0] err0;
  logic [9:0]  addr1;  logic [8:0]  wdata1; logic wr_req1, rd_req1;
  logic [7:0]  tx_data1; logic tx_send1, busy1; logic [7:0] err1;

  logic        m_wr_req, m_rd_req, m_req, m_tx_send;
  logic [7:0]  m_tx_data;
  assign m_wr_req  = sel ? wr_req1 : wr_req0;
  assign m_rd_req  = sel ? rd_req1 : rd_req0;
  assign m_req     = m_wr_req | m_rd_req;
  assign m_tx_send = sel ? tx_send1 : tx_send0;
  assign m_tx_data = sel ? tx_data1 : tx_data0;

  uart_mem_cmd_proc u_wide (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid && !sel),
    .mem_addr(addr0), .mem_wr_data(wdata0), .mem_wr_req(wr_req0), .mem_rd_req(rd_req0),
    .mem_wr_done(mem_done && !sel), .mem_rd_ready(mem_ready && !sel), .mem_rd_data(mem_rdata),
    .tx_data(tx_data0), .tx_send(tx_send0), .tx_busy(tx_busy), .busy(busy0), .err_count(err0)
  );

  uart_mem_cmd_proc #(.ADDR_W(10), .DATA_W(9), .TIMEOUT(16)) u_narrow (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid && sel),
    .mem_addr(addr1), .mem_wr_data(wdata1), .mem_wr_req(wr_req1), .mem_rd_req(rd_req1),
    .mem_wr_done(mem_done && sel), .mem_rd_ready(mem_ready && sel), .mem_rd_data(mem_rdata[8:0]),
    .tx_data(tx_data1), .tx_send(tx_send1), .tx_busy(tx_busy), .busy(busy1), .err_count(err1)
  );

  int checks = 0;
  int failures = 0;
  int req_cycles = 0;
  int tx_viol = 0;
  int busy_left = 0;
  logic tx_quiet = 1'b0;
  byte unsigned txq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: busy for 3 cycles after each byte unless quiet
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (m_req) req_cycles++;
      if (m_tx_send) begin
        if (tx_busy) tx_viol++;
        txq.push_back(m_tx_data);
        if (!tx_quiet) busy_left = 3;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      tx_busy = (busy_left > 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input byte unsigned b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Memory model: completion pulse in request cycle 'delay' (negative: never)
  task automatic mem_serve(input int delay, input logic [15:0] data, output int hi);
    hi = 0;
    for (int c = 0; c < 200; c++) begin
      if (!m_req) break;
      hi++;
      if (c == delay) begin
        mem_rdata = data;
        mem_done  = m_wr_req;
        mem_ready = m_rd_req;
      end
      @(negedge clk);
      mem_done  = 1'b0;
      mem_ready = 1'b0;
    end
  endtask

  task automatic expect_tx(input string tag, input string s);
    logic [63:0] got, exp;
    for (int c = 0; c < 300 && txq.size() < s.len(); c++) @(negedge clk);
    repeat (12) @(negedge clk);
    got = '0;
    exp = '0;
    foreach (txq[i]) got = {got[55:0], txq[i]};
    for (int i = 0; i < s.len(); i++) exp = {exp[55:0], 8'(s[i])};
    check(tag, got, exp);
    txq.delete();
  endtask

  initial begin
    int hi, n;
    sel = 1'b0; rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0;
    mem_done = 1'b0; mem_ready = 1'b0; mem_rdata = 16'd0;
    repeat (3) @(negedge clk);
    check("reset wide", {wr_req0, rd_req0, addr0, wdata0, tx_send0, tx_data0, busy0, err0}, 64'd0);
    check("reset narrow", {wr_req1, rd_req1, addr1, wdata1, tx_send1, tx_data1, busy1, err1}, 64'd0);
    rst = 1'b0;

    // Write, completion 5 cycles after request rises
    send_str("W000010A55A");
    check("wr req latency", {m_wr_req, m_rd_req}, 2'b10);
    check("wr addr", addr0, 24'h000010);
    check("wr data", wdata0, 16'hA55A);
    mem_serve(5, 16'h0, hi);
    check("wr req cycles", hi, 6);
    check("wr addr hold", {addr0, wdata0}, {24'h000010, 16'hA55A});
    expect_tx("wr resp", "K\r\n");

    // Read with lowercase input; transmitter never raises busy
    tx_quiet = 1'b1;
    send_str("r00001f");
    check("rd req latency", {m_wr_req, m_rd_req}, 2'b01);
    check("rd addr", addr0, 24'h00001F);
    mem_serve(3, 16'h00BE, hi);
    check("rd req cycles", hi, 4);
    expect_tx("rd resp", "00BE\r\n");
    tx_quiet = 1'b0;

    // Parse error, then a normal read
    n = req_cycles;
    send_str("W00G");
    expect_tx("parse resp", "?\r\n");
    check("parse no req", req_cycles - n, 0);
    check("parse err_count", err0, 1);
    send_str("R000000");
    check("rd2 req", {m_rd_req, addr0}, {1'b1, 24'h000000});
    mem_serve(0, 16'h1234, hi);
    check("rd2 req cycles", hi, 1);
    check("busy in resp", busy0, 1);
    send_str("W12");
    expect_tx("rd2 resp", "1234\r\n");
    send_str("\r\n ");
    repeat (10) @(negedge clk);
    check("idle after crlf", {busy0, 8'(txq.size())}, 9'd0);
    send_str("R00ABCD");
    check("rd3 addr", {m_rd_req, addr0}, {1'b1, 24'h00ABCD});
    mem_serve(2, 16'hF00D, hi);
    expect_tx("rd3 resp", "F00D\r\n");
    check("err_count unchanged", err0, 1);

    // Asynchronous reset while a write request is pending
    send_str("W123456BEEF");
    check("rst pre req", m_wr_req, 1);
    #2 rst = 1'b1;
    #1 check("rst async", {wr_req0, rd_req0, addr0, wdata0, tx_send0, tx_data0, busy0, err0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rst no resp", {busy0, 8'(txq.size())}, 9'd0);

    // Narrow instance: timeout, late ready, width truncation
    sel = 1'b1;
    send_str("R000");
    check("to req latency", m_rd_req, 1);
    mem_serve(-1, 16'h0, hi);
    check("to req cycles", hi, 16);
    mem_rdata = 16'h0055;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    expect_tx("to resp", "T\r\n");
    check("to err_count", err1, 1);

    send_str("W7FF1FF");
    check("nw req", m_wr_req, 1);
    check("nw addr", addr1, 10'h3FF);
    check("nw data", wdata1, 9'h1FF);
    mem_serve(1, 16'h0, hi);
    check("nw req cycles", hi, 2);
    expect_tx("nw resp", "K\r\n");

    send_str("R3FF");
    check("nr addr", {m_rd_req, addr1}, {1'b1, 10'h3FF});
    mem_serve(2, 16'h01FF, hi);
    expect_tx("nr resp", "1FF\r\n");
    check("nr err_count", err1, 1);

    check("tx protocol", tx_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
